// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_pkg
// Description : Shared definitions for the nibble-serial adder sequencer:
//               FSM state encodings and the nibble-index counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

    // Sequencer states; encodings are fixed so they stay stable across builds.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } nsa_state_t;

    // Counter width for the nibble index: max(1, clog2(nibbles)).
    function automatic int nsa_cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_ripple.sv
`default_nettype none
// ============================================================================
// Module      : rippleAdder4
// Description : 4-bit ripple-carry adder, the shared datapath element of the
//               nibble-serial adder sequencer.
// Ports       : a, b  - 4-bit addends
//               cin   - carry in
//               sum   - 4-bit sum
//               cout  - carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module rippleAdder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds two WIDTH-bit operands through one 4-bit ripple adder,
//               one nibble per clock, LSB nibble first. The inter-nibble carry
//               is held in a register. Handshake: start / busy / done pulse.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start           - request, sampled only in IDLE
//               a, b, cin       - operands and carry-in, captured on start
//               sub             - subtract select (only with NSA_SUB_EN)
//               busy            - high while nibbles are being processed
//               done            - one-cycle completion pulse
//               sum, cout, ovf  - registered result, held until next done
// Options     : `define NSA_SUB_EN adds the sub port (A - B via ~B + 1).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = nsa_cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    nsa_state_t                state, state_next;
    logic [CNT_W-1:0]          idx;
    logic                      carry;
    logic [NIBBLES-1:0][3:0]   op_a, op_b, result, full_result;
    logic [WIDTH-1:0]          b_eff;
    logic                      cin_eff;
    logic [3:0]                add_sum;
    logic                      add_cout;

    // Subtraction is folded into capture: storing ~B and forcing carry-in to 1
    // means the RUN datapath and the overflow check only ever see B'.
`ifdef NSA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    rippleAdder4 u_adder (
        .a    (op_a[idx]),
        .b    (op_b[idx]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Result including the nibble being computed this cycle, so the final
    // edge can publish a complete value without a partial-nibble window.
    always_comb begin
        full_result      = result;
        full_result[idx] = add_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: state_next = start ? RUN : IDLE;
            RUN: begin
                busy       = 1'b1;
                state_next = (idx == LAST_IDX) ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_eff;
                        carry <= cin_eff;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result[idx] <= add_sum;
                    carry       <= add_cout;
                    if (idx == LAST_IDX) begin
                        idx  <= '0;
                        sum  <= full_result;
                        cout <= add_cout;
                        ovf  <= (op_a[NIBBLES-1][3] == op_b[NIBBLES-1][3]) &&
                                (full_result[NIBBLES-1][3] != op_a[NIBBLES-1][3]);
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Directed self-checking bench for nibble_serial_adder_ctrl
//               (WIDTH=16). Subtract vectors run when NSA_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        sub;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Stimulus helper: issues one start and waits (bounded) for done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         output logic [15:0] s, output logic c, output logic o,
                         output int nbusy, output bit tmo);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        tmo   = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        s = sum; c = cout; o = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0F0F, 16'h8000};
        logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es [5] = '{16'h0100, 16'h0000, 16'h8000, 16'h2144, 16'h0000};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] s;
        logic        c, o;
        int          nb;
        bit          tmo;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, s, c, o, nb, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL add_timeout[%0d]: got no done expected done", i); end
            checks++; if (nb != 4) begin errors++; $display("FAIL add_busy_cycles[%0d]: got %0d expected 4", i, nb); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL add_sum[%0d]: got %h expected %h", i, s, es[i]); end
            checks++; if (c !== ec[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b expected %b", i, c, ec[i]); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, o, eo[i]); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done[%0d]: got %b expected 0", i, busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse[%0d]: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        int nd = 0;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                nd++;
                checks++; if (sum !== 16'h3333) begin errors++; $display("FAIL ignore_sum: got %h expected 3333", sum); end
                checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin
                    errors++; $display("FAIL ignore_flags: got cout=%b ovf=%b expected 0 0", cout, ovf);
                end
            end
            start = busy | done;
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] s;
        logic        c, o;
        int          nb;
        bit          tmo;
        int          nd = 0;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, s, c, o, nb, tmo);
        checks++; if (tmo || s !== 16'h2345) begin errors++; $display("FAIL pre_reset_sum: got %h expected 2345", s); end
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum: got %h expected 0000", sum); end
        checks++; if (done !== 1'b0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got done=%b cout=%b ovf=%b expected 0 0 0", done, cout, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", nd); end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, s, c, o, nb, tmo);
        checks++; if (tmo || s !== 16'h1000 || c !== 1'b0 || o !== 1'b0) begin
            errors++; $display("FAIL post_reset_op: got sum=%h cout=%b ovf=%b expected 1000 0 0", s, c, o);
        end
    endtask

    task automatic test_back_to_back();
        int          nd = 0;
        int          last_k = -1;
        logic [15:0] exp_sum = 16'h0000;
        @(negedge clk);
        a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                exp_sum = (nd == 1) ? 16'h0303 : 16'h1000;
                checks++; if (sum !== exp_sum) begin errors++; $display("FAIL b2b_sum[%0d]: got %h expected %h", nd, sum, exp_sum); end
                if (last_k >= 0) begin
                    checks++; if (k - last_k != 6) begin
                        errors++; $display("FAIL b2b_interval[%0d]: got %0d expected 6", nd, k - last_k);
                    end
                end
                last_k = k;
                if (nd == 1) begin
                    a = 16'h0FFF; b = 16'h0001;
                end
            end else if (nd >= 1) begin
                checks++; if (sum !== exp_sum) begin errors++; $display("FAIL b2b_hold: got %h expected %h", sum, exp_sum); end
            end
        end
        start = 1'b0;
        checks++; if (nd != 5) begin errors++; $display("FAIL b2b_done_count: got %0d expected 5", nd); end
        repeat (8) @(negedge clk);
    endtask

`ifdef NSA_SUB_EN
    task automatic test_sub();
        logic [15:0] s;
        logic        c, o;
        int          nb;
        bit          tmo;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, o, nb, tmo);
        checks++; if (tmo || s !== 16'hFFFE || c !== 1'b0 || o !== 1'b0) begin
            errors++; $display("FAIL sub_5_7: got sum=%h cout=%b ovf=%b expected fffe 0 0", s, c, o);
        end
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, s, c, o, nb, tmo);
        checks++; if (tmo || s !== 16'h7FFF || c !== 1'b1 || o !== 1'b1) begin
            errors++; $display("FAIL sub_8000_1: got sum=%h cout=%b ovf=%b expected 7fff 1 1", s, c, o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
`ifdef NSA_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
